// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the CPU requesters (fetch and data), the arbiter and the memory port.
// slave is the arbiter's view, master is the surrounding CPU/memory view.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        ir_ce;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mdr_ce;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_ack, i_rdata, ir_ce, d_ack, d_rdata, mdr_ce, bus_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_ack, i_rdata, ir_ce, d_ack, d_rdata, mdr_ce, bus_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data access,
// with D-priority arbitration, starvation guard for I, timeout abort and IR/MDR enables.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        owner_d;
    logic        just_done;
    logic [3:0]  streak;
    logic [7:0]  tcnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        we_q;
    logic        err_q;

    logic pick_i, pick_d, grant_i, grant_d, busy, i_ack_w, d_ack_w;

    // Winner by priority rules first; the masking below can only veto it, never hand
    // the slot to the other side, so a just-acked winner costs one wait cycle.
    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (bus.i_req && bus.d_req) begin
            if (streak == STREAK_MAX) pick_i = 1'b1;
            else                      pick_d = 1'b1;
        end else if (bus.i_req) begin
            pick_i = 1'b1;
        end else if (bus.d_req) begin
            pick_d = 1'b1;
        end
    end

    assign grant_i = (state == S_IDLE) && pick_i && !(just_done && !owner_d);
    assign grant_d = (state == S_IDLE) && pick_d && !(just_done && owner_d);
    assign busy    = (state == S_GRANT_I) || (state == S_GRANT_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            just_done <= 1'b0;
            streak    <= '0;
            tcnt      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            just_done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (grant_i || grant_d) begin
                        state   <= grant_i ? S_GRANT_I : S_GRANT_D;
                        owner_d <= grant_d;
                        tcnt    <= '0;
                        if (grant_i) begin
                            addr_q <= bus.i_addr;
                            we_q   <= 1'b0;
                        end else begin
                            addr_q  <= bus.d_addr;
                            we_q    <= bus.d_we;
                            wdata_q <= bus.d_wdata;
                        end
                    end
                    if (!bus.i_req || grant_i) streak <= '0;
                    else if (grant_d)          streak <= streak + 4'd1;
                end
                S_GRANT_I, S_GRANT_D: begin
                    // A completion in the last allowed cycle beats the timeout.
                    if (bus.mem_ack) begin
                        rdata_q <= bus.mem_rdata;
                        err_q   <= 1'b0;
                        state   <= S_DONE;
                    end else if (tcnt == TMO_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_ack_w = (state == S_DONE) && !owner_d;
    assign d_ack_w = (state == S_DONE) && owner_d;

    assign bus.i_ack     = i_ack_w;
    assign bus.d_ack     = d_ack_w;
    assign bus.i_rdata   = i_ack_w ? rdata_q : '0;
    assign bus.d_rdata   = d_ack_w ? rdata_q : '0;
    assign bus.bus_err   = err_q;
    assign bus.ir_ce     = i_ack_w && !err_q;
    assign bus.mdr_ce    = d_ack_w && !we_q && !err_q;
    assign bus.mem_req   = busy;
    assign bus.mem_we    = busy && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, starvation and
// reset sequences, then random traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          lat;        // busy cycles before mem_ack; >= TMO means never
        logic [31:0] mdata;
        logic        exp_d;
        int          exp_busy;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_ir_ce;
        logic        exp_mdr_ce;
    } vec_t;

    vec_t vecs [8];

    task automatic apply_vec(input vec_t v);
        int          n_busy;
        logic        moved;
        logic [31:0] exp_addr;
        exp_addr    = v.exp_d ? v.d_addr : v.i_addr;
        bus.i_req   = v.i_req;
        bus.i_addr  = v.i_addr;
        bus.d_req   = v.d_req;
        bus.d_we    = v.d_we;
        bus.d_addr  = v.d_addr;
        bus.d_wdata = v.d_wdata;
        chk1({v.name, " mem_req before grant"}, bus.mem_req, 1'b0);
        tick();
        chk1({v.name, " mem_req rise"}, bus.mem_req, 1'b1);
        chk32({v.name, " mem_addr"}, bus.mem_addr, exp_addr);
        chk1({v.name, " mem_we"}, bus.mem_we, v.exp_d && v.d_we);
        if (v.exp_d && v.d_we) chk32({v.name, " mem_wdata"}, bus.mem_wdata, v.d_wdata);
        n_busy = 0;
        moved  = 1'b0;
        while (bus.mem_req && n_busy < 300) begin
            if (bus.mem_addr !== exp_addr || bus.mem_we !== (v.exp_d && v.d_we)) moved = 1'b1;
            bus.mem_ack   = (n_busy == v.lat);
            bus.mem_rdata = bus.mem_ack ? v.mdata : $urandom;
            n_busy++;
            tick();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
        end
        chk1({v.name, " request held stable"}, moved, 1'b0);
        chk32({v.name, " mem_req cycles"}, n_busy, v.exp_busy);
        chk1({v.name, " i_ack"}, bus.i_ack, !v.exp_d);
        chk1({v.name, " d_ack"}, bus.d_ack, v.exp_d);
        chk1({v.name, " bus_err"}, bus.bus_err, v.exp_err);
        chk1({v.name, " ir_ce"}, bus.ir_ce, v.exp_ir_ce);
        chk1({v.name, " mdr_ce"}, bus.mdr_ce, v.exp_mdr_ce);
        if (v.chk_rdata)
            chk32({v.name, " rdata"}, v.exp_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        chk1({v.name, " ack is one pulse"}, bus.i_ack || bus.d_ack, 1'b0);
        tick();
    endtask

    // Random-phase agent helpers: a new request carries fresh payload and is held until acked.
    task automatic new_i();
        bus.i_req  = 1'b1;
        bus.i_addr = {$urandom_range(16'hFFFF), 2'b00, 14'h0} | 32'($urandom_range(255) << 2);
    endtask

    task automatic new_d();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
    endtask

    string       exp_order, got_order, side;
    int          w;
    // reference-model state for the random phase
    int          free_at, masked, streak, win, r;
    logic        act, a_d, a_we, a_err, exp_busy, exp_done, in_busy;
    logic [31:0] a_addr, a_wd, a_rd;
    int          a_start, a_lat, a_done;

    initial begin
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;

        vecs[0] = '{"fetch", 1, 32'h100, 0, 0, 0, 0, 0, 32'h8C010004,
                    0, 1, 1, 32'h8C010004, 0, 1, 0};
        vecs[1] = '{"store 3ws", 0, 0, 1, 1, 32'h2000, 32'hCAFEBABE, 3, 32'hDEADBEEF,
                    1, 4, 0, 0, 0, 0, 0};
        vecs[2] = '{"load", 0, 0, 1, 0, 32'h3004, 0, 1, 32'h12345678,
                    1, 2, 1, 32'h12345678, 0, 0, 1};
        vecs[3] = '{"fetch 2ws", 1, 32'h104, 0, 0, 0, 0, 2, 32'h00000013,
                    0, 3, 1, 32'h00000013, 0, 1, 0};
        vecs[4] = '{"load timeout", 0, 0, 1, 0, 32'h5000, 0, 999, 32'h77777777,
                    1, TMO, 1, 32'h0, 1, 0, 0};
        vecs[5] = '{"ack at timeout", 1, 32'h108, 0, 0, 0, 0, TMO - 1, 32'hA5A5A5A5,
                    0, TMO, 1, 32'hA5A5A5A5, 0, 1, 0};
        vecs[6] = '{"both pending", 1, 32'h200, 1, 0, 32'h4000, 0, 0, 32'h55AA55AA,
                    1, 1, 1, 32'h55AA55AA, 0, 0, 1};
        vecs[7] = '{"fetch timeout", 1, 32'h10C, 0, 0, 0, 0, 999, 32'h1,
                    0, TMO, 1, 32'h0, 1, 0, 0};

        tick();
        tick();
        chk1("reset mem_req", bus.mem_req, 1'b0);
        chk1("reset mem_we", bus.mem_we, 1'b0);
        chk32("reset mem_addr", bus.mem_addr, 32'h0);
        chk1("reset i_ack", bus.i_ack, 1'b0);
        chk1("reset d_ack", bus.d_ack, 1'b0);
        chk1("reset bus_err", bus.bus_err, 1'b0);
        chk1("reset ce", bus.ir_ce || bus.mdr_ce, 1'b0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) apply_vec(vecs[k]);

        // Starvation guard: both requesters held high throughout, memory acks at once.
        bus.i_addr = 32'h100; bus.d_addr = 32'h2000; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        exp_order = "DDDDIDDDDI";
        got_order = "";
        for (int g = 0; g < 10; g++) begin
            w = 0;
            while (!bus.mem_req && w < 10) begin
                tick();
                w++;
            end
            if (!bus.mem_req) begin
                chk1("starve grant wait", 1'b0, 1'b1);
                break;
            end
            side = (bus.mem_addr == 32'h2000) ? "D" : "I";
            got_order = {got_order, side};
            if (g > 0) chk32("starve gap", w, (exp_order[g] == exp_order[g-1]) ? 3 : 2);
            bus.mem_ack = 1'b1;
            bus.mem_rdata = 32'h0BADF00D;
            tick();
            bus.mem_ack = 1'b0;
            chk1("starve ack", (side == "D") ? bus.d_ack : bus.i_ack, 1'b1);
        end
        checks++;
        if (got_order != exp_order) begin
            errors++;
            $display("FAIL starve order: got %s, expected %s", got_order, exp_order);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick(); tick(); tick();

        // Reset in the middle of a fetch: access vanishes, held request is regranted.
        bus.i_req = 1'b1; bus.i_addr = 32'h300;
        tick(); tick(); tick();
        chk1("midrst busy", bus.mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("midrst mem_req async", bus.mem_req, 1'b0);
        chk1("midrst no i_ack", bus.i_ack, 1'b0);
        tick();
        chk1("midrst held i_ack", bus.i_ack, 1'b0);
        rst = 1'b0;
        w = 0;
        while (!bus.mem_req && w < 10) begin
            tick();
            w++;
        end
        chk32("midrst regrant latency", w, 1);
        chk32("midrst regrant addr", bus.mem_addr, 32'h300);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00C0FFEE;
        tick();
        bus.mem_ack = 1'b0;
        chk1("midrst i_ack", bus.i_ack, 1'b1);
        chk32("midrst i_rdata", bus.i_rdata, 32'h00C0FFEE);
        bus.i_req = 1'b0;
        tick(); tick();

        // Random traffic against a transaction-level model of the port.
        free_at = 0; masked = -1; streak = 0; act = 1'b0;
        a_d = 0; a_we = 0; a_err = 0; a_addr = 0; a_wd = 0; a_rd = 0;
        a_start = 0; a_lat = 0; a_done = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            exp_busy = act && cyc >= a_start && cyc < a_done;
            exp_done = act && cyc == a_done;
            chk1("rnd mem_req", bus.mem_req, exp_busy);
            if (exp_busy) begin
                chk32("rnd mem_addr", bus.mem_addr, a_addr);
                chk1("rnd mem_we", bus.mem_we, a_we);
                if (a_we) chk32("rnd mem_wdata", bus.mem_wdata, a_wd);
            end
            chk1("rnd i_ack", bus.i_ack, exp_done && !a_d);
            chk1("rnd d_ack", bus.d_ack, exp_done && a_d);
            chk1("rnd bus_err", bus.bus_err, exp_done && a_err);
            chk1("rnd ir_ce", bus.ir_ce, exp_done && !a_d && !a_err);
            chk1("rnd mdr_ce", bus.mdr_ce, exp_done && a_d && !a_we && !a_err);
            if (exp_done && !(a_d && a_we))
                chk32("rnd rdata", a_d ? bus.d_rdata : bus.i_rdata, a_err ? 32'h0 : a_rd);

            if (exp_done) begin
                act = 1'b0;
                free_at = cyc + 1;
                masked = a_d ? 1 : 0;
                if ($urandom_range(1) == 1) begin
                    if (a_d) new_d(); else new_i();
                end else begin
                    if (a_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
                end
            end
            if (!bus.i_req && $urandom_range(3) == 0) new_i();
            if (!bus.d_req && $urandom_range(2) == 0) new_d();

            if (!act && cyc == free_at) begin
                win = -1;
                if (bus.i_req && bus.d_req) win = (streak == MAXS) ? 0 : 1;
                else if (bus.i_req)         win = 0;
                else if (bus.d_req)         win = 1;
                if (win >= 0 && win == masked) win = -1;
                if (!bus.i_req || win == 0) streak = 0;
                else if (win == 1)          streak++;
                masked = -1;
                if (win >= 0) begin
                    act     = 1'b1;
                    a_d     = (win == 1);
                    a_addr  = a_d ? bus.d_addr : bus.i_addr;
                    a_we    = a_d && bus.d_we;
                    a_wd    = bus.d_wdata;
                    a_rd    = $urandom;
                    a_start = cyc + 1;
                    r = $urandom_range(99);
                    if (r < 3)      a_lat = 1000;
                    else if (r < 6) a_lat = TMO - 1;
                    else            a_lat = $urandom_range(4);
                    a_err  = (a_lat >= TMO);
                    a_done = a_err ? a_start + TMO : a_start + a_lat + 1;
                end else begin
                    free_at = cyc + 1;
                end
            end

            in_busy = act && cyc >= a_start && cyc < a_done;
            if (in_busy) begin
                bus.mem_ack   = (cyc - a_start == a_lat);
                bus.mem_rdata = bus.mem_ack ? a_rd : $urandom;
            end else begin
                bus.mem_ack   = ($urandom_range(3) == 0);
                bus.mem_rdata = $urandom;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 32-bit memory port between two requesters: instruction fetch (I) and data load/store (D). It sequences each access with a req/ack handshake on both sides. It also produces the clock-enable pulses for the instruction register and memory data register, which are 32-bit REG32-style registers with a CE input. Sits between the multi-cycle CPU control unit and the memory/bus interface.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I wins a tie (1..15)
TIMEOUT, 64, cycles in a busy state without mem_ack before the access is aborted (2..255)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_req  in  1  fetch request; held with i_addr until i_ack
i_addr  in  32  fetch word address
i_ack  out  1  one-cycle pulse: fetch complete
i_rdata  out  32  fetch data, valid while i_ack=1
ir_ce  out  1  IR clock enable; equals i_ack && !bus_err
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  32  load data, valid while d_ack=1
mdr_ce  out  1  MDR clock enable; equals d_ack && !d_we_latched && !bus_err
bus_err  out  1  qualifies the current i_ack/d_ack: access timed out
mem_req  out  1  memory request; held until mem_ack or timeout
mem_we  out  1  memory write strobe, qualified by mem_req
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, sampled when mem_ack=1
mem_ack  in  1  memory completion; ignored when mem_req=0

Behaviour:
- Reset: all outputs 0, state IDLE, streak and timeout counters 0. Reset asserted mid-access aborts the access immediately; no ack is issued.
- States and transitions:
  - IDLE -> GRANT_I or GRANT_D when a request is eligible.
  - GRANT_x -> DONE on mem_ack or timeout.
  - DONE -> IDLE.
- IDLE:
  - Samples i_req and d_req and chooses a winner.
  - Latches addr, we, and wdata into internal registers; mem_* outputs drive from these registers only.
  - mem_req rises the cycle after the grant decision.
- Arbitration:
  - Only one requester pending: it wins.
  - Both pending: D wins, unless streak == MAX_D_STREAK, in which case I wins.
  - Streak increments on each D grant made while i_req=1.
  - Streak clears on any I grant and on any IDLE cycle with i_req=0.
- GRANT_x:
  - mem_req=1 and addresses held stable.
  - On mem_ack=1: capture mem_rdata, drop mem_req the next cycle, go to DONE.
  - mem_ack may arrive in the first mem_req cycle.
- DONE (exactly one cycle):
  - Assert the winner's ack with the captured rdata.
  - Assert ir_ce or mdr_ce as defined in Ports.
  - Return to IDLE.
  - The requester that was just acked is masked from arbitration for that IDLE cycle, since its req may still be high.
- Timeout:
  - A counter clears on grant and increments each GRANT_x cycle without mem_ack.
  - At TIMEOUT: drop mem_req, go to DONE with bus_err=1 and rdata=32'h0.
  - A store is not retried.
  - A mem_ack arriving in the same cycle as the timeout takes priority: normal completion.
- Minimum latency: req at cycle 0, mem_req at cycle 1, mem_ack at cycle 1, ack at cycle 2.
- Requests that drop before their ack are unsupported; the arbiter completes the access regardless.
- mem_ack outside GRANT_x is ignored.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, memory acks in the same cycle with 0x8C010004 -> mem_req at cycle 1; i_ack=1, ir_ce=1, i_rdata=0x8C010004 at cycle 2; bus_err=0.
- Store with 3 wait states: d_we=1, d_addr=0x2000, d_wdata=0xCAFEBABE -> mem_we=1 and mem_wdata held for 4 cycles; d_ack at the 5th cycle after mem_req rises; mdr_ce=0.
- Load: d_we=0, mem_rdata=0x12345678 -> d_ack=1, mdr_ce=1, d_rdata=0x12345678 in the same cycle; ir_ce=0.
- Starvation: i_req and d_req held high continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; no back-to-back grant to the requester just acked.
- Timeout: memory never acks, TIMEOUT=64 -> mem_req low after 64 busy cycles; d_ack=1 and bus_err=1 with d_rdata=0. Same-cycle mem_ack at cycle 64 -> normal completion with bus_err=0.
- Reset mid-access: rst pulsed during GRANT_I -> mem_req=0 asynchronously, no i_ack; after release, a held i_req is re-granted from IDLE.
